regfile_write_arbiter: RTL and testbench

- Shares the register file's single synchronous write port between two writeback requesters.
- Requester 0 is the core ALU/load writeback. Requester 1 is the secondary source (debug/context restore).
- Round-robin arbitration with optional burst locking and a lock timeout.
- Registered output stage drives the register file's write_reg, write_data and reg_write inputs.

---
 rtl/regfile_write_arbiter_if.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : regfile_write_arbiter_if
// Description : Bundles the two writeback requester channels and the register
//               file write-port outputs of regfile_write_arbiter.
//               master : requester / register-file side (drives the requests)
//               slave  : arbiter side (drives ready and the write port)
//               Signals: reqN_valid/reg/data/lock, reqN_ready, reg_write,
//               write_reg, write_data, grant_id, locked.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_lock;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_lock;
    logic              req1_ready;

    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              grant_id;
    logic              locked;

    modport master (
        output req0_valid, req0_reg, req0_data, req0_lock,
        output req1_valid, req1_reg, req1_data, req1_lock,
        input  req0_ready, req1_ready,
        input  reg_write, write_reg, write_data, grant_id, locked
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data, req0_lock,
        input  req1_valid, req1_reg, req1_data, req1_lock,
        output req0_ready, req1_ready,
        output reg_write, write_reg, write_data, grant_id, locked
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between two
//               writeback requesters (0 = ALU/load, 1 = debug/context restore).
//               Round-robin arbitration with burst locking and a lock timeout,
//               followed by a registered write-port stage.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - slave modport: request channels in, ready and
//                       register-file write port (reg_write, write_reg,
//                       write_data), grant_id and locked out
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int MAX_LOCK = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int                 c_CNT_W   = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               w_last_nxt;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic               w_rdy0;
    logic               w_rdy1;
    logic               w_xfer0;
    logic               w_xfer1;
    logic               w_xfer;
    logic               w_xfer_id;
    logic               w_xfer_lock;
    logic [ADDR_W-1:0]  w_sel_reg;
    logic [DATA_W-1:0]  w_sel_data;

    logic               r_reg_write;
    logic [ADDR_W-1:0]  r_write_reg;
    logic [DATA_W-1:0]  r_write_data;
    logic               r_grant_id;

    // Ready depends only on the registered state and the request valids, so
    // the two readies are mutually exclusive by construction.
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    // Contention: the requester that did not win last time.
                    w_rdy0 = r_last_grant;
                    w_rdy1 = !r_last_grant;
                end else begin
                    w_rdy0 = bus.req0_valid;
                    w_rdy1 = bus.req1_valid;
                end
            end
            // A lock reserves the port even while its owner is idle.
            ST_LOCK0: w_rdy0 = 1'b1;
            ST_LOCK1: w_rdy1 = 1'b1;
            default: begin
                w_rdy0 = 1'b0;
                w_rdy1 = 1'b0;
            end
        endcase
        // Nothing may be accepted while the flops are held in reset.
        if (reset) begin
            w_rdy0 = 1'b0;
            w_rdy1 = 1'b0;
        end
    end

    assign w_xfer0     = bus.req0_valid && w_rdy0;
    assign w_xfer1     = bus.req1_valid && w_rdy1;
    assign w_xfer      = w_xfer0 || w_xfer1;
    assign w_xfer_id   = w_xfer1;
    assign w_xfer_lock = w_xfer1 ? bus.req1_lock : bus.req0_lock;
    assign w_sel_reg   = w_xfer1 ? bus.req1_reg  : bus.req0_reg;
    assign w_sel_data  = w_xfer1 ? bus.req1_data : bus.req0_data;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_lock_cnt;
        if (w_xfer) begin
            w_last_nxt = w_xfer_id;
        end
        case (r_state)
            ST_ARB: begin
                // Counter is parked at zero so a new lock always starts fresh.
                w_cnt_nxt = '0;
                if (w_xfer && w_xfer_lock) begin
                    w_state_nxt = w_xfer_id ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                w_cnt_nxt = r_lock_cnt + c_CNT_W'(1);
                if (w_xfer && !w_xfer_lock) begin
                    w_state_nxt = ST_ARB;
                end
                // Timeout overrides the owner's lock request; naming the owner
                // as last grant hands the next contention to the other side.
                if (r_lock_cnt == c_CNT_MAX) begin
                    w_state_nxt = ST_ARB;
                    w_last_nxt  = (r_state == ST_LOCK1);
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ARB;
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_lock_cnt   <= w_cnt_nxt;
        end
    end

    // Write-port stage: address/data/owner hold between beats, the enable is a
    // single-cycle pulse. Beats to x0 are consumed but never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_grant_id   <= 1'b0;
        end else begin
            r_reg_write <= w_xfer && (w_sel_reg != '0);
            if (w_xfer) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
                r_grant_id   <= w_xfer_id;
            end
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.grant_id   = r_grant_id;
    assign bus.locked     = (r_state != ST_ARB);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. A cycle model
//               predicts ready, locked and the accepted beats; accepted beats
//               are queued and compared when they reach the write port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int MAX_LOCK = 4;

    logic clk;
    logic reset;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MAX_LOCK(MAX_LOCK)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
        logic              g;
    } beat_t;

    beat_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: m_mode = -1 when arbitrating, else lock owner.
    int                m_mode;
    int                m_last;
    int                m_cnt;
    logic [ADDR_W-1:0] h_reg;
    logic [DATA_W-1:0] h_data;
    logic              h_gid;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = -1;
        m_last = 1;
        m_cnt  = 0;
        h_reg  = '0;
        h_data = '0;
        h_gid  = 1'b0;
        sb.delete();
    endtask

    task automatic drive(input logic v0, input int r0, input logic [DATA_W-1:0] d0, input logic l0,
                         input logic v1, input int r1, input logic [DATA_W-1:0] d1, input logic l1);
        bus.req0_valid = v0;
        bus.req0_reg   = ADDR_W'(r0);
        bus.req0_data  = d0;
        bus.req0_lock  = l0;
        bus.req1_valid = v1;
        bus.req1_reg   = ADDR_W'(r1);
        bus.req1_data  = d1;
        bus.req1_lock  = l1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_reg_write"},  64'(bus.reg_write),  64'd0);
        check_val({tag, "_write_reg"},  64'(bus.write_reg),  64'd0);
        check_val({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
        check_val({tag, "_grant_id"},   64'(bus.grant_id),   64'd0);
        check_val({tag, "_locked"},     64'(bus.locked),     64'd0);
        check_val({tag, "_rdy0"},       64'(bus.req0_ready), 64'd0);
        check_val({tag, "_rdy1"},       64'(bus.req1_ready), 64'd0);
    endtask

    // One clock cycle with the inputs currently driven. Ready is checked on
    // the falling edge, outputs 1 time unit after the rising edge.
    task automatic cycle();
        logic  e0, e1;
        int    xf, n_mode, n_last, n_cnt;
        logic  lk;
        beat_t b;
        @(negedge clk);
        if (m_mode < 0) begin
            if (bus.req0_valid && bus.req1_valid) begin
                e0 = (m_last == 1);
                e1 = (m_last == 0);
            end else begin
                e0 = bus.req0_valid;
                e1 = bus.req1_valid;
            end
        end else begin
            e0 = (m_mode == 0);
            e1 = (m_mode == 1);
        end
        check_val("req0_ready", 64'(bus.req0_ready), 64'(e0));
        check_val("req1_ready", 64'(bus.req1_ready), 64'(e1));

        xf = -1;
        lk = 1'b0;
        if (bus.req0_valid && e0) begin
            xf  = 0;
            lk  = bus.req0_lock;
            b.r = bus.req0_reg;
            b.d = bus.req0_data;
        end else if (bus.req1_valid && e1) begin
            xf  = 1;
            lk  = bus.req1_lock;
            b.r = bus.req1_reg;
            b.d = bus.req1_data;
        end
        if (xf >= 0) begin
            b.rw = (b.r != '0);
            b.g  = (xf == 1);
            sb.push_back(b);
        end

        n_mode = m_mode;
        n_last = m_last;
        n_cnt  = m_cnt;
        if (xf >= 0) n_last = xf;
        if (m_mode < 0) begin
            if (xf >= 0 && lk) begin
                n_mode = xf;
                n_cnt  = 0;
            end
        end else begin
            n_cnt = m_cnt + 1;
            if (xf >= 0 && !lk) n_mode = -1;
            if (m_cnt == MAX_LOCK - 1) begin
                n_mode = -1;
                n_last = m_mode;
            end
        end

        @(posedge clk);
        #1;
        m_mode = n_mode;
        m_last = n_last;
        m_cnt  = n_cnt;

        if (sb.size() != 0) begin
            b = sb.pop_front();
            h_reg  = b.r;
            h_data = b.d;
            h_gid  = b.g;
            check_val("beat_reg_write", 64'(bus.reg_write), 64'(b.rw));
        end else begin
            check_val("idle_reg_write", 64'(bus.reg_write), 64'd0);
        end
        check_val("write_reg",  64'(bus.write_reg),  64'(h_reg));
        check_val("write_data", 64'(bus.write_data), 64'(h_data));
        check_val("grant_id",   64'(bus.grant_id),   64'(h_gid));
        check_val("locked",     64'(bus.locked),     64'(m_mode >= 0));
    endtask

    // Asserts reset wherever we are in the cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_zero_outputs(tag);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 3, 64'h1, 1'b0, 1'b1, 4, 64'h2, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("in_reset");
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
        reset = 1'b0;

        // Single requester 0 beat, then an idle cycle.
        drive(1'b1, 3, 64'hAAAA, 1'b0, 1'b0, 0, 64'h0, 1'b0);
        cycle();
        check_val("single_reg_write", 64'(bus.reg_write), 64'd1);
        check_val("single_write_reg", 64'(bus.write_reg), 64'd3);
        check_val("single_write_data", bus.write_data, 64'hAAAA);
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
        cycle();

        // Round robin from reset: 0,1,0,1 then one more 0.
        do_reset("rr_reset");
        drive(1'b1, 1, 64'h1111, 1'b0, 1'b1, 2, 64'h2222, 1'b0);
        cycle();
        check_val("rr_first_grant", 64'(bus.grant_id), 64'd0);
        for (int i = 0; i < 4; i++) cycle();

        // Requester 1 burst of 4 under lock while requester 0 waits.
        drive(1'b1, 1, 64'h1111, 1'b0, 1'b1, 10, 64'hB0, 1'b1);
        cycle();
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1, 64'h1111, 1'b0, 1'b1, 10 + i, 64'(64'hB0 + i), (i != 3));
            cycle();
            check_val("burst_locked", 64'(bus.locked), (i != 3) ? 64'd1 : 64'd0);
        end

        // Requester 0 claims and holds the lock until the timeout forces release.
        drive(1'b1, 6, 64'hC0DE, 1'b1, 1'b1, 7, 64'hD00D, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
        check_val("forced_release_grant", 64'(bus.grant_id), 64'd1);

        // Write to x0 is accepted but not performed.
        drive(1'b1, 0, 64'hFFFF, 1'b0, 1'b0, 0, 64'h0, 1'b0);
        cycle();
        check_val("x0_reg_write", 64'(bus.reg_write), 64'd0);
        drive(1'b1, 5, 64'h5555, 1'b0, 1'b0, 0, 64'h0, 1'b0);
        cycle();
        check_val("x5_reg_write", 64'(bus.reg_write), 64'd1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), {$urandom, $urandom},
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), {$urandom, $urandom},
                  1'($urandom_range(0, 2) == 0));
            cycle();
        end

        // Reset in the middle of a lock with a beat pending.
        do_reset("pre_lock_reset");
        drive(1'b1, 7, 64'h7777, 1'b1, 1'b0, 0, 64'h0, 1'b0);
        cycle();
        drive(1'b1, 9, 64'h9999, 1'b1, 1'b1, 8, 64'h8888, 1'b0);
        cycle();
        check_val("midlock_locked", 64'(bus.locked), 64'd1);
        do_reset("midlock_reset");
        drive(1'b1, 12, 64'h1200, 1'b0, 1'b1, 13, 64'h1300, 1'b0);
        cycle();
        check_val("post_reset_grant", 64'(bus.grant_id), 64'd0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
